tt_um_cnt_checker: RTL and testbench
====================================

TT_UM_CNT_CHECKER -- requirements
Module: tt_um_cnt_checker

Interface
REQ-001 The module SHALL use a reset named rst_n, which is asynchronous and active-low, and a clock named clk.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock for all state.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-004 The port ena SHALL be an input, 1 bit wide, and is ignored.
REQ-005 The port ui_in SHALL be an input, 8 bits wide: [0] is the check enable en, [1] is the synchronous stats clear clr, [3:2] is the display select sel, and [7:4] are unused.
REQ-006 The port uio_in SHALL be an input, 8 bits wide, and carries the data stream under check, one sample per clk.
REQ-007 The port uo_out SHALL be an output, 8 bits wide, and is the display byte chosen by sel.
REQ-008 The port uio_out SHALL be an output, 8 bits wide, tied to 8'h00.
REQ-009 The port uio_oe SHALL be an output, 8 bits wide, tied to 8'h00, so all uio pins are always inputs.

Function
REQ-010 The block SHALL check that uio_in follows an incrementing modulo-256 sequence, one step per clk: the receiving end of an 8-bit free-running counter output.
REQ-011 uio_in SHALL be registered into d_q on every clk edge; the previous d_q SHALL be held in p_q; a step is good when d_q == p_q + 1 (8-bit wrap, so 0xFF->0x00 is good).
REQ-012 State machine states and encodings SHALL be IDLE=2'd0, HUNT=2'd1, LOCK=2'd2; 2'd3 is unreachable and SHALL recover to IDLE.
REQ-013 From any state, en=0 SHALL give IDLE on the next edge; counters hold and run_q/miss_q clear.
REQ-014 IDLE with en=1 SHALL go to HUNT with run_q=0.
REQ-015 HUNT: a good step increments run_q; a bad step zeroes run_q; the edge on which run_q would reach 3 SHALL enter LOCK with miss_q=0; no errors are counted in HUNT.
REQ-016 LOCK: a good step SHALL increment good_q (8-bit, wraps) and zero miss_q; a bad step SHALL increment err_q (saturating at 255) and miss_q.
REQ-017 LOCK: the second consecutive bad step SHALL count in err_q and move to HUNT with run_q=0.
REQ-018 clr=1 SHALL zero err_q and good_q on that edge, overriding any simultaneous increment; state, run_q and miss_q are unaffected.
REQ-019 Latency: a sample present at uio_in before edge k SHALL affect state/counters at edge k+1, visible on uo_out after edge k+1.
REQ-020 uo_out SHALL be a combinational mux of registers: sel=0 gives {4'b0, err_q!=0, state==LOCK, state[1:0]}; sel=1 gives err_q; sel=2 gives good_q; sel=3 gives d_q.

Reset
REQ-021 When rst_n is low, every flop SHALL clear asynchronously (d_q, p_q, run_q, miss_q, err_q, good_q = 0; state = IDLE), giving uo_out = 8'h00 for all sel.
REQ-022 Reset deassertion SHALL be synchronised through one flop (rst_i) as in other blocks; rst_i gates all logic, so the first state update occurs on the second clk edge after rst_n rises.
REQ-023 Reset asserted mid-LOCK SHALL abort immediately; there is no retained statistic.

Configuration
REQ-024 The block SHALL honour the macro CNT_CHK_ERRCNT_EN: when defined, err_q is the 8-bit saturating counter of REQ-016; when undefined, err_q is a 1-bit sticky flag set by any LOCK bad step and cleared by clr/reset, sel=1 shows {7'b0, flag}, and REQ-020 bit 3 equals the flag.

Verification
REQ-025 Reset, then en=1 and uio_in=0,1,2,... -> status 8'h01 (HUNT), then 8'h06 (LOCK) once three good steps are seen; err_q=0.
REQ-026 Locked with uio_in stepping 0xFD,0xFE,0xFF,0x00,0x01 -> err_q stays 0; good_q increments by 4 across the wrap.
REQ-027 Locked, then inject one glitch (…,0x10,0x55,0x56,…) -> err_q=1 (or flag=1 without the macro), stays in LOCK since 0x56=0x55+1, status 8'h0E.
REQ-028 Locked, then inject two consecutive bad steps (…,0x20,0x80,0x10,…) -> err_q=2, state returns to HUNT (status 8'h09), relocks after 3 good steps.
REQ-029 Saturation and clr: force 300 LOCK errors -> err_q=255; pulse clr for 1 cycle concurrent with an error -> err_q=0, good_q=0, state unchanged.
REQ-030 Locked, then en=0 -> IDLE (status 8'h08 if err_q!=0) with counters held; assert rst_n low mid-stream -> uo_out=8'h00 immediately.

Source files
------------

// File: rtl/tt_um_cnt_checker.sv
// tt_um_cnt_checker: receive-side checker for an 8-bit free-running counter
// stream on uio_in. It hunts for three consecutive +1 steps and then locks.
// While locked, it counts good steps and error steps.
// Build option CNT_CHK_ERRCNT_EN: when defined, the error statistic is an 8-bit
// saturating counter. When undefined, it is a 1-bit sticky flag.
module tt_um_cnt_checker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int DATA_W = 8;
`ifdef CNT_CHK_ERRCNT_EN
    localparam int ERR_W = 8;
`else
    localparam int ERR_W = 1;
`endif
    localparam logic [1:0] RUN_LAST = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        LOCK = 2'd2
    } state_t;

    // Saturating increment; for a 1-bit statistic this is a sticky set.
    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    logic              en, clr;
    logic [1:0]        sel;
    logic              rst_i;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] d_q, p_q, p_inc;
    logic [1:0]        run_q, run_d;
    logic              miss_q, miss_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [7:0]        good_q, good_d;
    logic              good_step;
    logic              unused_ok;

    assign en        = ui_in[0];
    assign clr       = ui_in[1];
    assign sel       = ui_in[3:2];
    assign p_inc     = p_q + 8'd1;
    assign good_step = (d_q == p_inc);
    assign uio_out   = 8'h00;
    assign uio_oe    = 8'h00;
    assign unused_ok = &{1'b0, ena, ui_in[7:4]};

    // Reset assertion acts immediately; release is retimed through rst_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_i <= 1'b0;
        else        rst_i <= 1'b1;
    end

    // State register; it only advances once rst_i has been released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     state_q <= IDLE;
        else if (rst_i) state_q <= state_d;
    end

    // Sample history and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q    <= '0;
            p_q    <= '0;
            run_q  <= '0;
            miss_q <= 1'b0;
            err_q  <= '0;
            good_q <= '0;
        end else if (rst_i) begin
            d_q    <= uio_in;
            p_q    <= d_q;
            run_q  <= run_d;
            miss_q <= miss_d;
            err_q  <= err_d;
            good_q <= good_d;
        end
    end

    // Next state and statistics. The step being judged is p_q -> d_q.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        miss_d  = miss_q;
        err_d   = err_q;
        good_d  = good_q;
        if (!en) begin
            state_d = IDLE;
            run_d   = '0;
            miss_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = HUNT;
                    run_d   = '0;
                end
                HUNT: begin
                    if (!good_step) begin
                        run_d = '0;
                    end else if (run_q == RUN_LAST) begin
                        state_d = LOCK;
                        run_d   = '0;
                        miss_d  = 1'b0;
                    end else begin
                        run_d = run_q + 2'd1;
                    end
                end
                LOCK: begin
                    if (good_step) begin
                        good_d = good_q + 8'd1;
                        miss_d = 1'b0;
                    end else begin
                        err_d = err_sat_inc(err_q);
                        if (miss_q) begin
                            state_d = HUNT;
                            run_d   = '0;
                            miss_d  = 1'b0;
                        end else begin
                            miss_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                    miss_d  = 1'b0;
                end
            endcase
        end
        if (clr) begin
            err_d  = '0;
            good_d = '0;
        end
    end

    // Display mux: a pure register view selected by sel.
    always_comb begin
        uo_out = 8'h00;
        case (sel)
            2'd0:    uo_out = {4'b0000, |err_q, state_q == LOCK, state_q};
`ifdef CNT_CHK_ERRCNT_EN
            2'd1:    uo_out = err_q;
`else
            2'd1:    uo_out = {7'b0, err_q};
`endif
            2'd2:    uo_out = good_q;
            default: uo_out = d_q;
        endcase
    end

endmodule

// File: tb/tb_tt_um_cnt_checker.sv
// Self-checking bench for tt_um_cnt_checker. It uses a behavioural model of
// the hunt/lock rules that is updated once per clock edge.
module tb_tt_um_cnt_checker;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b1;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] cur    = 8'h00;

`ifdef CNT_CHK_ERRCNT_EN
    localparam logic [7:0] ERR_TWO  = 8'd2;
    localparam logic [7:0] ERR_MANY = 8'd255;
`else
    localparam logic [7:0] ERR_TWO  = 8'd1;
    localparam logic [7:0] ERR_MANY = 8'd1;
`endif

    tt_um_cnt_checker dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #10 clk = ~clk;

    // Reference model: 0 idle, 1 hunting, 2 locked; the error count is unbounded.
    bit m_live;
    int m_state, m_run, m_miss, m_err, m_good;
    int m_hist[$];

    task automatic model_reset();
        m_live  = 1'b0;
        m_state = 0;
        m_run   = 0;
        m_miss  = 0;
        m_err   = 0;
        m_good  = 0;
        m_hist  = '{0, 0};
    endtask

    task automatic model_edge(input bit en, input bit clr, input logic [7:0] data);
        bit good;
        if (!m_live) begin
            m_live = 1'b1;
            return;
        end
        good = (m_hist[1] == (m_hist[0] + 1) % 256);
        if (!en) begin
            m_state = 0; m_run = 0; m_miss = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_run = 0;
        end else if (m_state == 1) begin
            m_run = good ? m_run + 1 : 0;
            if (m_run == 3) begin m_state = 2; m_miss = 0; end
        end else if (good) begin
            m_good = (m_good + 1) % 256;
            m_miss = 0;
        end else begin
            m_err++;
            m_miss++;
            if (m_miss == 2) begin m_state = 1; m_run = 0; m_miss = 0; end
        end
        if (clr) begin m_err = 0; m_good = 0; end
        m_hist.push_back(int'(data));
        void'(m_hist.pop_front());
    endtask

    function automatic logic [7:0] exp_out(input int sel);
        case (sel)
            0: return 8'(m_state + ((m_state == 2) ? 4 : 0) + ((m_err != 0) ? 8 : 0));
`ifdef CNT_CHK_ERRCNT_EN
            1: return 8'((m_err > 255) ? 255 : m_err);
`else
            1: return (m_err != 0) ? 8'd1 : 8'd0;
`endif
            2: return 8'(m_good);
            default: return 8'(m_hist[1]);
        endcase
    endfunction

    // One clock: inputs change on the falling edge; outputs are settled 1 ns after the rising edge.
    task automatic tick(input bit en, input bit clr, input logic [7:0] data);
        @(negedge clk);
        ui_in[0]   = en;
        ui_in[1]   = clr;
        ui_in[7:4] = 4'($urandom);
        uio_in     = data;
        cur        = data;
        @(posedge clk);
        model_edge(en, clr, data);
        #1;
    endtask

    task automatic run_to(input logic [7:0] target);
        while (cur != target) tick(1'b1, 1'b0, cur + 8'd1);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ui_in  = 8'h01;
        uio_in = 8'h37;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        for (int s = 0; s < 4; s++) begin
            ui_in[3:2] = 2'(s);
            #1;
            checks++;
            if (uo_out !== 8'h00) begin
                errors++; $display("FAIL reset_uo_out sel=%0d got=%h exp=00", s, uo_out);
            end
        end
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++; $display("FAIL reset_uio got out=%h oe=%h exp=00/00", uio_out, uio_oe);
        end
        ui_in[3:2] = 2'd0;
        rst_n = 1'b1;
    endtask

    task automatic test_lock_acquire();
        logic [7:0] base;
        base = 8'($urandom_range(0, 200));
        ui_in[3:2] = 2'd0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, base + 8'(i));
            checks++;
            if (uo_out !== exp_out(0)) begin
                errors++; $display("FAIL acquire_status tick=%0d got=%h exp=%h", i, uo_out, exp_out(0));
            end
            if (i == 0) begin
                checks++;
                if (uo_out !== 8'h00) begin
                    errors++; $display("FAIL acquire_first_edge got=%h exp=00", uo_out);
                end
            end
            if (i == 1) begin
                checks++;
                if (uo_out !== 8'h01) begin
                    errors++; $display("FAIL acquire_hunt got=%h exp=01", uo_out);
                end
            end
        end
        checks++;
        if (uo_out !== 8'h06) begin
            errors++; $display("FAIL acquire_locked got=%h exp=06", uo_out);
        end
        ui_in[3:2] = 2'd1; #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++; $display("FAIL acquire_err got=%h exp=00", uo_out);
        end
        ui_in[3:2] = 2'd0;
    endtask

    task automatic test_wrap();
        int ga;
        run_to(8'hFE);
        ui_in[3:2] = 2'd2; #1;
        checks++;
        if (uo_out !== exp_out(2)) begin
            errors++; $display("FAIL wrap_good_before got=%h exp=%h", uo_out, exp_out(2));
        end
        ga = m_good;
        tick(1'b1, 1'b0, 8'hFF);
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h01);
        tick(1'b1, 1'b0, 8'h02);
        checks++;
        if (uo_out !== 8'((ga + 4) % 256)) begin
            errors++; $display("FAIL wrap_good_delta got=%h exp=%h", uo_out, 8'((ga + 4) % 256));
        end
        ui_in[3:2] = 2'd1; #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++; $display("FAIL wrap_err got=%h exp=00", uo_out);
        end
        ui_in[3:2] = 2'd0; #1;
        checks++;
        if (uo_out !== 8'h06) begin
            errors++; $display("FAIL wrap_status got=%h exp=06", uo_out);
        end
    endtask

    task automatic test_glitch();
        tick(1'b1, 1'b1, cur + 8'd1);
        ui_in[3:2] = 2'd1; #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++; $display("FAIL glitch_clr_err got=%h exp=00", uo_out);
        end
        ui_in[3:2] = 2'd2; #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++; $display("FAIL glitch_clr_good got=%h exp=00", uo_out);
        end
        ui_in[3:2] = 2'd0;
        run_to(8'h10);
        tick(1'b1, 1'b0, 8'h55);
        for (int v = 8'h56; v <= 8'h5A; v++) begin
            tick(1'b1, 1'b0, 8'(v));
            checks++;
            if (uo_out !== exp_out(0)) begin
                errors++; $display("FAIL glitch_track v=%h got=%h exp=%h", v, uo_out, exp_out(0));
            end
        end
        checks++;
        if (uo_out !== 8'h0E) begin
            errors++; $display("FAIL glitch_status got=%h exp=0e", uo_out);
        end
        ui_in[3:2] = 2'd1; #1;
        checks++;
        if (uo_out !== 8'h01) begin
            errors++; $display("FAIL glitch_err got=%h exp=01", uo_out);
        end
        ui_in[3:2] = 2'd0;
    endtask

    task automatic test_double_bad();
        tick(1'b1, 1'b1, cur + 8'd1);
        run_to(8'h20);
        tick(1'b1, 1'b0, 8'h80);
        tick(1'b1, 1'b0, 8'h10);
        tick(1'b1, 1'b0, 8'h11);
        checks++;
        if (uo_out !== 8'h09) begin
            errors++; $display("FAIL double_hunt got=%h exp=09", uo_out);
        end
        ui_in[3:2] = 2'd1; #1;
        checks++;
        if (uo_out !== ERR_TWO) begin
            errors++; $display("FAIL double_err got=%h exp=%h", uo_out, ERR_TWO);
        end
        ui_in[3:2] = 2'd0;
        for (int v = 8'h12; v <= 8'h13; v++) begin
            tick(1'b1, 1'b0, 8'(v));
            checks++;
            if (uo_out !== exp_out(0)) begin
                errors++; $display("FAIL double_track v=%h got=%h exp=%h", v, uo_out, exp_out(0));
            end
        end
        tick(1'b1, 1'b0, 8'h14);
        checks++;
        if (uo_out !== 8'h0E) begin
            errors++; $display("FAIL double_relock got=%h exp=0e", uo_out);
        end
        ui_in[3:2] = 2'd3; #1;
        checks++;
        if (uo_out !== 8'h14) begin
            errors++; $display("FAIL double_data got=%h exp=14", uo_out);
        end
        ui_in[3:2] = 2'd0;
    endtask

    task automatic test_saturate_clr();
        logic [7:0] v;
        tick(1'b1, 1'b1, cur + 8'd1);
        for (int i = 0; i < 300; i++) begin
            v = 8'($urandom);
            if (v == cur + 8'd1) v = v + 8'd2;
            tick(1'b1, 1'b0, v);
            tick(1'b1, 1'b0, v + 8'd1);
            checks++;
            if (uo_out !== exp_out(0)) begin
                errors++; $display("FAIL sat_track i=%0d got=%h exp=%h", i, uo_out, exp_out(0));
            end
        end
        ui_in[3:2] = 2'd1; #1;
        checks++;
        if (uo_out !== ERR_MANY) begin
            errors++; $display("FAIL sat_err got=%h exp=%h", uo_out, ERR_MANY);
        end
        v = 8'($urandom);
        if (v == cur + 8'd1) v = v + 8'd2;
        tick(1'b1, 1'b0, v);
        tick(1'b1, 1'b1, v + 8'd1);
        checks++;
        if (uo_out !== 8'h00) begin
            errors++; $display("FAIL clr_err got=%h exp=00", uo_out);
        end
        ui_in[3:2] = 2'd2; #1;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++; $display("FAIL clr_good got=%h exp=00", uo_out);
        end
        ui_in[3:2] = 2'd0; #1;
        checks++;
        if (uo_out !== 8'h06) begin
            errors++; $display("FAIL clr_state got=%h exp=06", uo_out);
        end
    endtask

    task automatic test_random();
        bit         en, clr;
        int         sel;
        logic [7:0] data;
        for (int i = 0; i < 200; i++) begin
            en   = ($urandom_range(0, 15) != 0);
            clr  = ($urandom_range(0, 31) == 0);
            data = ($urandom_range(0, 7) == 0) ? 8'($urandom) : cur + 8'd1;
            tick(en, clr, data);
            sel = $urandom_range(0, 3);
            ui_in[3:2] = 2'(sel); #1;
            checks++;
            if (uo_out !== exp_out(sel)) begin
                errors++; $display("FAIL random i=%0d sel=%0d got=%h exp=%h", i, sel, uo_out, exp_out(sel));
            end
        end
        ui_in[3:2] = 2'd0;
    endtask

    task automatic test_disable_reset();
        int g;
        ui_in[3:2] = 2'd0;
        repeat (8) tick(1'b1, 1'b0, cur + 8'd1);
        tick(1'b1, 1'b0, cur + 8'd5);
        repeat (3) tick(1'b1, 1'b0, cur + 8'd1);
        checks++;
        if (uo_out !== 8'h0E) begin
            errors++; $display("FAIL disable_pre got=%h exp=0e", uo_out);
        end
        g = m_good;
        tick(1'b0, 1'b0, cur + 8'd1);
        checks++;
        if (uo_out !== 8'h08) begin
            errors++; $display("FAIL disable_idle got=%h exp=08", uo_out);
        end
        ui_in[3:2] = 2'd2; #1;
        checks++;
        if (uo_out !== 8'(g)) begin
            errors++; $display("FAIL disable_good_hold got=%h exp=%h", uo_out, 8'(g));
        end
        tick(1'b1, 1'b0, cur + 8'd1);
        tick(1'b1, 1'b0, cur + 8'd1);
        rst_n = 1'b0;
        model_reset();
        for (int s = 0; s < 4; s++) begin
            ui_in[3:2] = 2'(s); #1;
            checks++;
            if (uo_out !== 8'h00) begin
                errors++; $display("FAIL midreset sel=%0d got=%h exp=00", s, uo_out);
            end
        end
        ui_in[3:2] = 2'd0;
        rst_n = 1'b1;
        tick(1'b1, 1'b0, cur + 8'd1);
        checks++;
        if (uo_out !== 8'h00) begin
            errors++; $display("FAIL post_reset_first got=%h exp=00", uo_out);
        end
        tick(1'b1, 1'b0, cur + 8'd1);
        checks++;
        if (uo_out !== 8'h01) begin
            errors++; $display("FAIL post_reset_hunt got=%h exp=01", uo_out);
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_wrap();
        test_glitch();
        test_double_bad();
        test_saturate_clr();
        test_random();
        test_disable_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
